// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared types and helpers for the sequential divider (seq_div / div_step).
//   divState_t   : FSM state encoding {IDLE, ITER, FIN}
//   MAX_W        : widest operand the helper functions can handle
//   cntWidth()   : iteration-counter width, clog2(N+1) with N = width/bpc
//   paramsLegal(): elaboration-time legality of WIDTH / BITS_PER_CYCLE
//   abs_val()    : conditional two's-complement negation (magnitude / sign fix)
// ---------------------------------------------------------------------------
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIN  = 2'd2
  } divState_t;

  localparam int MAX_W = 64;

  function automatic int cntWidth(input int width, input int bpc);
    return $clog2(width / bpc + 1);
  endfunction

  function automatic bit paramsLegal(input int width, input int bpc);
    return ((bpc == 1) || (bpc == 2) || (bpc == 4)) &&
           (width >= 4) && ((width % 2) == 0) &&
           ((width % bpc) == 0) && (width <= MAX_W);
  endfunction

  // Callers zero-extend into MAX_W and truncate the result back to their own
  // width; the low bits of a two's-complement negation never depend on the
  // high bits, so this is exact for every width up to MAX_W.
  function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] x,
                                               input logic neg);
    return neg ? (~x + MAX_W'(1)) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational restoring-division step on a (WIDTH+1)-bit partial
// remainder.
//   partRem  in  WIDTH+1  partial remainder before this step
//   divisor  in  WIDTH    divisor magnitude
//   inBit    in  1        next dividend bit shifted in at the bottom
//   nextRem  out WIDTH+1  partial remainder after this step
//   qBit     out 1        quotient bit produced by this step (1 = no borrow)
// ---------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   partRem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             inBit,
  output logic [WIDTH:0]   nextRem,
  output logic             qBit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] divisorExt;
  logic [WIDTH:0] diff;

  assign shifted    = {partRem[WIDTH-1:0], inBit};
  assign divisorExt = {1'b0, divisor};
  assign diff       = shifted - divisorExt;

  // The partial remainder always stays below the divisor, so its top bit is
  // normally zero; if it were set, the shifted value would certainly exceed
  // the divisor, hence it forces a "no borrow" decision.
  assign qBit    = partRem[WIDTH] | (shifted >= divisorExt);
  assign nextRem = qBit ? diff : shifted;

endmodule

// File: rtl/seq_div.sv
// ---------------------------------------------------------------------------
// seq_div
// Multi-cycle restoring integer divider for the DIV/DIVU path (LO = quotient,
// HI = remainder). Performs BITS_PER_CYCLE restoring steps per clock; an
// operation takes N+1 busy cycles, N = WIDTH/BITS_PER_CYCLE.
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   request, sampled only while busy=0
//   is_signed    in   1 = two's-complement divide, captured with start
//   flush        in   synchronous abort of an operation in flight
//   dividend     in   WIDTH, captured on the accepting edge
//   divisor      in   WIDTH, captured on the accepting edge
//   busy         out  high while an operation is in flight
//   done         out  one-cycle pulse, results valid
//   div_by_zero  out  divisor was zero, valid with done and held afterwards
//   quotient     out  WIDTH, held stable from done until replaced
//   remainder    out  WIDTH, held stable from done until replaced
// Rounding truncates toward zero; a nonzero remainder takes the dividend's
// sign. MIN / -1 wraps to q = MIN, r = 0. Division by zero yields
// q = all ones and r = the untouched dividend.
// ---------------------------------------------------------------------------
module seq_div
  import div_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic             flush,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int N        = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W    = cntWidth(WIDTH, BITS_PER_CYCLE);
  localparam bit ParamsOk = paramsLegal(WIDTH, BITS_PER_CYCLE);

  if (!ParamsOk) begin : gIllegalParams
    $error("seq_div: WIDTH must be even, >= 4, <= 64 and divisible by BITS_PER_CYCLE in {1,2,4}");
  end

  divState_t        state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   partRem;
  logic [WIDTH-1:0] quoShift;
  logic [WIDTH-1:0] divisorMag;
  logic [WIDTH-1:0] rawDividend;
  logic             qSign;
  logic             rSign;
  logic             zeroDiv;

  logic             dividendNeg;
  logic             divisorNeg;
  logic [WIDTH-1:0] dividendMag;
  logic [WIDTH-1:0] divisorMagIn;
  logic [WIDTH-1:0] quoFixed;
  logic [WIDTH-1:0] remFixed;

  // Operand magnitudes at accept time and sign-corrected results at finish.
  always_comb begin
    dividendNeg  = is_signed & dividend[WIDTH-1];
    divisorNeg   = is_signed & divisor[WIDTH-1];
    dividendMag  = WIDTH'(abs_val(MAX_W'(dividend), dividendNeg));
    divisorMagIn = WIDTH'(abs_val(MAX_W'(divisor), divisorNeg));
    quoFixed     = WIDTH'(abs_val(MAX_W'(quoShift), qSign));
    remFixed     = WIDTH'(abs_val(MAX_W'(partRem[WIDTH-1:0]), rSign));
  end

  // quoShift doubles as the dividend shift register: dividend bits leave at
  // the top while quotient bits enter at the bottom, so after N iterations
  // it holds the quotient magnitude.
  logic [WIDTH:0]      remChain [BITS_PER_CYCLE+1];
  logic [WIDTH-1:0]    quoChain [BITS_PER_CYCLE+1];
  logic [BITS_PER_CYCLE-1:0] qBits;

  assign remChain[0] = partRem;
  assign quoChain[0] = quoShift;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : gStep
    div_step #(
      .WIDTH (WIDTH)
    ) uStep (
      .partRem (remChain[i]),
      .divisor (divisorMag),
      .inBit   (quoChain[i][WIDTH-1]),
      .nextRem (remChain[i+1]),
      .qBit    (qBits[i])
    );
    assign quoChain[i+1] = {quoChain[i][WIDTH-2:0], qBits[i]};
  end

  // Control FSM and all datapath/output registers. done is a single-cycle
  // pulse, so it defaults low every edge. A flush only matters while busy
  // and leaves the previously published result untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      partRem     <= '0;
      quoShift    <= '0;
      divisorMag  <= '0;
      rawDividend <= '0;
      qSign       <= 1'b0;
      rSign       <= 1'b0;
      zeroDiv     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      done <= 1'b0;
      if (flush && busy) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              rawDividend <= dividend;
              quoShift    <= dividendMag;
              divisorMag  <= divisorMagIn;
              partRem     <= '0;
              qSign       <= dividendNeg ^ divisorNeg;
              rSign       <= dividendNeg;
              zeroDiv     <= (divisor == '0);
              cnt         <= CNT_W'(N);
              busy        <= 1'b1;
              state       <= ITER;
            end
          end
          ITER: begin
            partRem  <= remChain[BITS_PER_CYCLE];
            quoShift <= quoChain[BITS_PER_CYCLE];
            cnt      <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state <= FIN;
            end
          end
          FIN: begin
            if (zeroDiv) begin
              quotient    <= '1;
              remainder   <= rawDividend;
              div_by_zero <= 1'b1;
            end else begin
              quotient    <= quoFixed;
              remainder   <= remFixed;
              div_by_zero <= 1'b0;
            end
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/seq_div.md
Name: seq_div

Overview:
- Multi-cycle, parametrised integer divider for the CPU's DIV/DIVU path; produces the values written to LO (quotient) and HI (remainder).
- Successor to the fully combinational array divider, with the following additions:
  - iterative datapath (one or more restoring steps per clock)
  - signed/unsigned mode
  - start/busy/done handshake and flush
  - defined divide-by-zero result
  - WIDTH-bit remainder instead of a 2*WIDTH-bit one

Parameters:
- WIDTH, 32, operand/result width in bits; even, >= 4.
- BITS_PER_CYCLE, 1, restoring steps per clock; legal values 1, 2, 4; must divide WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- is_signed  in  1  1 = two's-complement divide, 0 = unsigned; captured with start.
- flush  in  1  synchronous abort of an operation in flight.
- dividend  in  WIDTH  captured on the accepting edge.
- divisor  in  WIDTH  captured on the accepting edge.
- busy  out  WIDTH-independent 1  high while an operation is in flight.
- done  out  1  one-cycle pulse; results valid.
- div_by_zero  out  1  valid with done; held until the next accept.
- quotient  out  WIDTH  held stable from done until the next accept.
- remainder  out  WIDTH  held stable from done until the next accept.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - state = IDLE
  - busy, done, div_by_zero = 0
  - quotient, remainder = 0
  - all internal registers = 0
- Constant: N = WIDTH/BITS_PER_CYCLE.
- State machine states: IDLE, ITER, FIN.
- IDLE:
  - If start=1 at edge E0: latch is_signed and the raw operands.
  - Load magnitudes: |x| if is_signed and MSB set, else x.
  - Latch the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign), both signed mode only.
  - Set cnt=N, busy<=1, state<=ITER.
- ITER:
  - Each edge performs BITS_PER_CYCLE restoring steps on a (WIDTH+1)-bit partial remainder:
    - shift in the next dividend bit
    - trial-subtract the divisor
    - quotient bit = no-borrow
    - keep the difference on no-borrow, otherwise restore
  - cnt decrements; when cnt reaches 1 at the edge, state<=FIN.
- FIN (edge E(N+1)):
  - Apply signs: negate quotient if q_sign, negate remainder if r_sign.
  - Register the outputs, done<=1, busy<=0, state<=IDLE.
  - done clears on the next edge.
- Latency: done is high in the cycle after edge E(N+1); busy is high for exactly N+1 cycles.
- Back-to-back: start may be asserted during the done cycle and is accepted there (busy=0).
- start while busy=1: ignored; no queuing.
- Rounding: the quotient truncates toward zero; a nonzero remainder takes the dividend's sign. Example: -7/2 gives q=-3, r=-1.
- Signed overflow, MIN / -1:
  - q = MIN (the magnitude 2^(WIDTH-1) wraps), r = 0.
  - div_by_zero = 0; no separate overflow flag.
- Divisor = 0 (detected at accept):
  - Same latency as a normal divide.
  - Result: quotient = all ones, remainder = original dividend, unmodified by sign fix, div_by_zero = 1.
- flush:
  - When flush=1 and busy=1: state<=IDLE, busy<=0, done is not pulsed.
  - quotient, remainder and div_by_zero retain their previous values.
  - flush has priority over start in the same cycle; flush while idle has no effect.
- Reset asserted mid-operation: immediate return to reset values; no done.
- Arithmetic: all internal adders are WIDTH+1 bits; no result ever depends on bits above WIDTH.

Decomposition:
- Package div_pkg:
  - state enum {IDLE, ITER, FIN}
  - function log2-based counter width: CNT_W = clog2(N+1)
  - helper function abs_val
  - localparam legality check on BITS_PER_CYCLE (elaboration error if illegal)
- Sub-module div_step: combinational single restoring step.
  - Inputs: partial remainder (WIDTH+1), divisor (WIDTH), incoming dividend bit.
  - Outputs: next partial remainder, quotient bit.
  - Chained BITS_PER_CYCLE times in a generate loop inside seq_div.

Test Plan:
- WIDTH=32, K=1, unsigned 100/7, start at E0 -> done during the cycle after E33, q=14, r=2, div_by_zero=0, busy high for 33 cycles.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) -> q=0xFFFFFFFD, r=0xFFFFFFFF. The same operands unsigned -> q=0x7FFFFFFC, r=1.
- Divisor zero, signed, dividend 0x80000005 -> q=0xFFFFFFFF, r=0x80000005, div_by_zero=1, same latency. Signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0.
- Start 50/5 and hold start high through busy with changing operands -> one done only, q=10, r=0. Assert start again in the done cycle -> second op accepted, done N+1 cycles later.
- flush at E10 of an op -> busy=0 next cycle, no done pulse, outputs keep the prior result. rst_n pulsed low mid-op (asynchronously, off-edge) -> outputs 0 immediately.
- WIDTH=16, K=4, 0xFFFF/0x0003 unsigned -> q=0x5555, r=0, done after E5 (N=4); randomised compare against a reference model over 10k ops for K in {1,2,4}.
